// File: rtl/code_density_histogrammer.sv
// Per-code histogram of ADC samples: clear sequencing, sample target, saturating
// bins with read-modify-write forwarding, and a host readout port.
module code_density_histogrammer #(
    parameter int unsigned CODE_WIDTH   = 10,
    parameter int unsigned COUNT_WIDTH  = 16,
    parameter int unsigned TARGET_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [TARGET_WIDTH-1:0] n_samples,
    input  logic                    fifo_empty,
    output logic                    fifo_rd_en,
    input  logic [CODE_WIDTH-1:0]   fifo_rd_data,
    input  logic                    rb_en,
    input  logic [CODE_WIDTH-1:0]   rb_addr,
    output logic [COUNT_WIDTH-1:0]  rb_data,
    output logic                    rb_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    sat_flag,
    output logic [TARGET_WIDTH-1:0] sample_count
);
    localparam int unsigned DEPTH = 2 ** CODE_WIDTH;
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CODE_WIDTH-1:0]  LAST_BIN = '1;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ACQUIRE, S_DRAIN, S_DONE} state_e;

    state_e                  state_q, state_d;
    logic [CODE_WIDTH-1:0]   clr_addr_q, clr_addr_d;
    logic [TARGET_WIDTH-1:0] target_q, target_d;
    logic [TARGET_WIDTH-1:0] issued_q, issued_d;
    logic [TARGET_WIDTH-1:0] sample_count_q, sample_count_d;
    logic                    sat_q, sat_d;
    logic                    s1_valid_q, s1_valid_d;
    logic                    s2_valid_q, s2_valid_d;
    logic [CODE_WIDTH-1:0]   s2_code_q, s2_code_d;
    logic                    fwd_q, fwd_d;
    logic [COUNT_WIDTH-1:0]  fwd_val_q, fwd_val_d;
    logic                    rb_valid_q, rb_valid_d;
    logic [COUNT_WIDTH-1:0]  rb_data_q, rb_data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic [COUNT_WIDTH-1:0]  ram [DEPTH];
    logic [COUNT_WIDTH-1:0]  ram_rd_q;
    logic                    ram_we;
    logic [CODE_WIDTH-1:0]   ram_waddr;
    logic [COUNT_WIDTH-1:0]  ram_wdata;

    logic [COUNT_WIDTH-1:0]  old_val;
    logic [COUNT_WIDTH-1:0]  inc_val;
    logic                    sat_hit;

    // Increment stage; a write to the same bin last cycle overrides stale RAM data
    always_comb begin
        old_val    = fwd_q ? fwd_val_q : ram_rd_q;
        sat_hit    = s2_valid_q && (old_val == CNT_MAX);
        inc_val    = sat_hit ? old_val : old_val + COUNT_WIDTH'(1);
        s1_valid_d = fifo_rd_en;
        s2_valid_d = s1_valid_q;
        s2_code_d  = fifo_rd_data;
        fwd_d      = s1_valid_q && s2_valid_q && (fifo_rd_data == s2_code_q);
        fwd_val_d  = inc_val;
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = s2_code_q;
        ram_wdata = inc_val;
        if (state_q == S_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr_q;
            ram_wdata = '0;
        end else if (s2_valid_q) begin
            ram_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
        ram_rd_q <= ram[fifo_rd_data];
    end

    always_comb begin
        state_d        = state_q;
        clr_addr_d     = clr_addr_q;
        target_d       = target_q;
        issued_d       = issued_q;
        sample_count_d = sample_count_q + TARGET_WIDTH'(s2_valid_q);
        sat_d          = sat_q | sat_hit;
        fifo_rd_en     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d        = S_CLEAR;
                    clr_addr_d     = '0;
                    target_d       = n_samples;
                    issued_d       = '0;
                    sample_count_d = '0;
                    sat_d          = 1'b0;
                end
            end
            S_CLEAR: begin
                clr_addr_d = clr_addr_q + CODE_WIDTH'(1);
                if (clr_addr_q == LAST_BIN) begin
                    state_d = S_ACQUIRE;
                end
            end
            S_ACQUIRE: begin
                fifo_rd_en = !fifo_empty && ((target_q == '0) || (issued_q < target_q)) && !stop;
                if (fifo_rd_en) begin
                    issued_d = issued_q + TARGET_WIDTH'(1);
                end
                if (stop || ((target_q != '0) && (issued_q == target_q))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!s1_valid_q && !s2_valid_q) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d     = (state_d == S_CLEAR) || (state_d == S_ACQUIRE);
        done_d     = (state_d == S_DONE);
        rb_valid_d = rb_en && !busy_q;
        rb_data_d  = rb_valid_d ? ram[rb_addr] : rb_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            clr_addr_q     <= '0;
            target_q       <= '0;
            issued_q       <= '0;
            sample_count_q <= '0;
            sat_q          <= 1'b0;
            s1_valid_q     <= 1'b0;
            s2_valid_q     <= 1'b0;
            s2_code_q      <= '0;
            fwd_q          <= 1'b0;
            fwd_val_q      <= '0;
            rb_valid_q     <= 1'b0;
            rb_data_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            clr_addr_q     <= clr_addr_d;
            target_q       <= target_d;
            issued_q       <= issued_d;
            sample_count_q <= sample_count_d;
            sat_q          <= sat_d;
            s1_valid_q     <= s1_valid_d;
            s2_valid_q     <= s2_valid_d;
            s2_code_q      <= s2_code_d;
            fwd_q          <= fwd_d;
            fwd_val_q      <= fwd_val_d;
            rb_valid_q     <= rb_valid_d;
            rb_data_q      <= rb_data_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign rb_data      = rb_data_q;
    assign rb_valid     = rb_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign sat_flag     = sat_q;
    assign sample_count = sample_count_q;

endmodule

// File: doc/code_density_histogrammer.md
Name: code_density_histogrammer

Overview:
- Parametrised successor to the single-mode Histogrammer in the ADC code-density path.
- Pops ADC codes from the upstream FIFO at up to one per cycle and increments a per-code bin held in an internal dual-port RAM.
- Adds the following, none of which the single-mode block has:
  - bin clear sequencing
  - a programmable sample target
  - saturating counts
  - read-modify-write hazard forwarding
  - an independent bin readout port for the host/UART side.

Parameters:
- CODE_WIDTH, 10, ADC code width. Number of bins is DEPTH = 2**CODE_WIDTH.
- COUNT_WIDTH, 16, bin counter width.
- TARGET_WIDTH, 32, width of the sample-target and sample-counter registers.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: clear all bins, then acquire
- stop  in  1  one-cycle pulse: abort acquisition
- n_samples  in  TARGET_WIDTH  sample target, sampled on start; 0 = unlimited
- fifo_empty  in  1  upstream FIFO empty
- fifo_rd_en  out  1  FIFO pop request
- fifo_rd_data  in  CODE_WIDTH  FIFO data, valid the cycle after fifo_rd_en
- rb_en  in  1  readout request
- rb_addr  in  CODE_WIDTH  readout bin index
- rb_data  out  COUNT_WIDTH  readout bin count
- rb_valid  out  1  rb_data valid
- busy  out  1  high in CLEAR or ACQUIRE
- done  out  1  high in DONE
- sat_flag  out  1  sticky; some bin saturated since last start
- sample_count  out  TARGET_WIDTH  samples accumulated since last start

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs 0. Pipeline valids cleared. RAM contents undefined until the next CLEAR.
- State machine:
  - IDLE: on start -> CLEAR. Latch n_samples; zero sample_count and sat_flag.
  - CLEAR: writes 0 to bins 0..DEPTH-1, one per cycle, so exactly DEPTH cycles. Then -> ACQUIRE. start/stop ignored in this state.
  - ACQUIRE: fifo_rd_en = !fifo_empty && (target==0 || issued < target) && !stop. "issued" counts pops.
    - -> DRAIN on stop, or when issued==target and target!=0.
  - DRAIN: no pops. Waits until the pipeline is empty (at most 3 cycles), then -> DONE.
  - DONE: holds. On start -> CLEAR; restart is allowed.
- start is ignored in ACQUIRE and DRAIN.
- Pipeline, for a pop at cycle t:
  - t+1: fifo_rd_data latched as code; RAM port A read issued at addr=code.
  - t+2: RAM read data valid; new = old+1; written to port A at t+2.
  - Throughput is 1 sample per cycle. sample_count increments at t+2.
- Hazard forwarding (mandatory):
  - If the code at stage t+1 equals the code being written at the same cycle, the increment at t+2 uses the forwarded written value, not the stale RAM data.
  - Back-to-back identical codes must each count exactly once.
- Saturation: if old == 2**COUNT_WIDTH-1, write back unchanged and set sat_flag. sat_flag stays set until the next start.
- sample_count counts every popped sample, including samples that hit a saturated bin.
- stop arriving on the same cycle as a target hit: same result (DRAIN).
- Readout (port B):
  - Accepted only when !busy. rb_data = ram[rb_addr] one cycle after rb_en; rb_valid pulses with it.
  - rb_en while busy: rb_valid stays 0 and rb_data holds its last value.
- Reset mid-operation: aborts immediately. The next start re-clears all bins.

Test Plan:
- Ramp: codes 0..1023 pushed once each at 1 per 3 cycles, start with n_samples=1024 -> done=1, all bins read back 1, sample_count=1024, sat_flag=0.
- Back-to-back hazard: codes 5,5,5,5,5,9,5 on consecutive cycles, n_samples=7 -> bin5=6, bin9=1, all other bins 0.
- Saturation with COUNT_WIDTH=4: 20 consecutive code-7 samples -> bin7=15, sat_flag=1, sample_count=20.
- Target/stop:
  - n_samples=100 with the FIFO holding 150 -> exactly 100 pops, 50 left in the FIFO.
  - n_samples=0 with stop after 37 pops -> done, sample_count=37.
- Readout gating: rb_en during ACQUIRE -> rb_valid=0. After done, rb_addr=5 -> rb_valid and rb_data=6 one cycle later.
- Reset mid-ACQUIRE: rst=0 for 2 cycles -> busy=0, done=0, sample_count=0. A subsequent start re-clears all bins (all 0 after CLEAR, verified via readout with an empty FIFO and stop).
